// File: rtl/fifo_wr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_wr_pkg : shared types and constants for the async FIFO write side |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fifo_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HOLD = 2'd2
  } wr_state_t;

  localparam int c_addr_size   = 8;
  localparam int c_hfull_thresh = 172;
  // Entries still free whenever hfull is low; bounds the largest safe burst.
  localparam int c_free_space  = (1 << c_addr_size) - c_hfull_thresh;

endpackage
`default_nettype wire

// File: rtl/fifo_skid2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_skid2 : 2-entry FIFO-ordered skid buffer, head zeroed when empty |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fifo_skid2 #(
  parameter int W = 9
) (
  input  logic         w_clk,
  input  logic         w_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_valid,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem0;
  logic [W-1:0] r_mem1;
  logic [1:0]   r_cnt;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_mem0 <= '0;
      r_mem1 <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_mem0 <= i_data;
          else               r_mem1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_mem0 <= r_mem1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_data;
          end else begin
            r_mem0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_full  = (r_cnt == 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_head  = o_valid ? r_mem0 : '0;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_wr_burst_ctrl : burst-admission write front end of the async FIFO |
// | Optional stall statistics: define WR_BURST_STATS_EN.  Rev 1.0      |
// +--------------------------------------------------------------------+
module fifo_wr_burst_ctrl
  import fifo_wr_pkg::*;
#(
  parameter int D_Width   = 8,
  parameter int MAX_BURST = 64,
  parameter int CNT_W     = 16
) (
  input  logic               w_clk,
  input  logic               w_rst,
  input  logic               s_valid,
  input  logic [D_Width-1:0] s_data,
  input  logic               s_last,
  output logic               s_ready,
  input  logic               wfull,
  input  logic               hfull,
  output logic               w_inc,
  output logic [D_Width-1:0] w_data,
  output logic               busy,
  output logic               err_len,
  output logic [CNT_W-1:0]   burst_cnt,
  output logic [15:0]        stall_cyc
);

  localparam int c_beat_w = $clog2(MAX_BURST + 1);

  generate
    if (MAX_BURST < 1 || MAX_BURST > c_free_space) begin : g_bad_max_burst
      $error("MAX_BURST must lie in 1..%0d", c_free_space);
    end
  endgenerate

  wr_state_t           r_state;
  logic [c_beat_w-1:0] r_beat;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic                r_err_len;

  logic               w_skid_full;
  logic               w_head_valid;
  logic [D_Width:0]   w_head;
  logic               w_head_last;
  logic [c_beat_w-1:0] w_beat_nxt;
  logic               w_at_max;

  fifo_skid2 #(.W(D_Width + 1)) u_skid (
    .w_clk   (w_clk),
    .w_rst   (w_rst),
    .i_push  (s_valid & s_ready),
    .i_data  ({s_last, s_data}),
    .i_pop   (w_inc),
    .o_full  (w_skid_full),
    .o_valid (w_head_valid),
    .o_head  (w_head)
  );

  assign w_head_last = w_head[D_Width];
  assign w_beat_nxt  = r_beat + c_beat_w'(1);
  assign w_at_max    = (w_beat_nxt == c_beat_w'(MAX_BURST));

  // Write strobe gated by the registered full flag so no beat lands in a full FIFO.
  assign w_inc     = (r_state == XFER) && w_head_valid && !wfull;
  assign w_data    = w_head[D_Width-1:0];
  assign s_ready   = !w_skid_full;
  assign busy      = (r_state != IDLE);
  assign err_len   = r_err_len;
  assign burst_cnt = r_burst_cnt;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_burst_cnt <= '0;
      r_err_len   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_head_valid && !hfull) r_state <= XFER;
        XFER: begin
          if (w_inc) begin
            if (w_head_last || w_at_max) begin
              r_burst_cnt <= r_burst_cnt + CNT_W'(1);
              r_beat      <= '0;
              r_state     <= IDLE;
              if (!w_head_last) r_err_len <= 1'b1;
            end else begin
              r_beat <= w_beat_nxt;
            end
          end else if (wfull) begin
            r_state <= HOLD;
          end
        end
        HOLD: if (!wfull) r_state <= XFER;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef WR_BURST_STATS_EN
  logic        w_stall;
  logic [15:0] r_stall_cyc;

  assign w_stall = (r_state == HOLD) || ((r_state == IDLE) && w_head_valid && hfull);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst)                                  r_stall_cyc <= 16'd0;
    else if (w_stall && r_stall_cyc != 16'hFFFF) r_stall_cyc <= r_stall_cyc + 16'd1;
  end

  assign stall_cyc = r_stall_cyc;
`else
  assign stall_cyc = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/fifo_wr_burst_ctrl.md
Name: fifo_wr_burst_ctrl

Overview:
- Write-side front end of the async FIFO, in the w_clk domain, directly upstream of the write pointer / full-flag stage.
- Accepts packets from a valid/ready source and buffers them in a 2-entry skid buffer.
- Admits a burst only when the FIFO is below the half-full threshold, then drives w_inc/w_data one beat per cycle while the FIFO is not full.
- Never issues a write into a full FIFO, and flags packets longer than MAX_BURST.

Parameters:
- D_Width, 8, data width of source and FIFO write data.
- MAX_BURST, 64, maximum beats per burst; must be ≤ 84, the free space guaranteed when hfull=0.
- CNT_W, 16, width of the completed-burst counter.

Ports:
- w_clk  in  1  write-domain clock
- w_rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  source beat valid
- s_data  in  D_Width  source beat data
- s_last  in  1  final beat of packet
- s_ready  out  1  block can accept a beat
- wfull  in  1  registered FIFO full from the write-pointer stage
- hfull  in  1  FIFO half-full (≥172 entries) from the write-pointer stage
- w_inc  out  1  FIFO write enable
- w_data  out  D_Width  FIFO write data
- busy  out  1  state != IDLE
- err_len  out  1  sticky: a burst hit MAX_BURST without s_last
- burst_cnt  out  CNT_W  completed bursts, wraps
- stall_cyc  out  16  optional statistics (see Optional Feature)

Behaviour:
- Reset (async): skid buffer empty, state=IDLE, beat counter=0, err_len=0, burst_cnt=0, stall_cyc=0.
  - Outputs during reset: w_inc=0, w_data=0, s_ready=1, busy=0.
- Skid buffer: 2 entries, FIFO order.
  - s_ready=1 iff occupancy<2; computed from registers only, with no combinational path from wfull/hfull.
  - Push on s_valid&s_ready. Pop on w_inc. Push and pop in the same cycle keep occupancy unchanged.
  - w_data is the head entry, driven as 0 when the buffer is empty.
- FSM:
  - IDLE: if head valid and hfull=0 → XFER at the next edge. hfull is sampled only in IDLE.
  - XFER: w_inc = head valid & !wfull.
    - On a beat with s_last=1, or when the beat count reaches MAX_BURST: burst_cnt++, beat count=0, → IDLE.
    - If wfull=1 → HOLD.
  - HOLD: w_inc=0; → XFER when wfull=0.
- w_inc is asserted only in XFER, never while wfull=1, and never with an empty buffer.
- An empty buffer in XFER (source gap) stays in XFER with w_inc=0.
- Latency: a beat captured at edge N with the buffer empty and hfull=0 gives state=XFER after edge N+1, with w_inc high in the cycle ending at edge N+2.
- Over-length packet: at the MAX_BURST-th beat without s_last, set err_len=1 (cleared only by reset) and close the burst. The remaining beats form a new burst that goes through hfull admission again.
- Beat counter: width clog2(MAX_BURST+1); resets to 0 whenever the burst closes.
- hfull rising during XFER does not stop the burst. Admission of MAX_BURST ≤ free space guarantees no overflow.
- Reset mid-burst: everything clears immediately. Beats already written stay in the FIFO, and no further writes occur.

Optional Feature:
- Macro WR_BURST_STATS_EN.
- Defined: stall_cyc counts cycles in HOLD plus cycles in IDLE with head valid and hfull=1. It saturates at 16'hFFFF and resets to 0.
- Undefined: stall_cyc tied to 0 and no counter logic is instantiated.

Decomposition:
- Package fifo_wr_pkg:
  - state enum {IDLE, XFER, HOLD}
  - FIFO address-size constant 8
  - HFULL threshold constant 172
  - derived free-space constant 84, used for a parameter range check on MAX_BURST
- Sub-module fifo_skid2: the 2-entry skid buffer (push/pop/occupancy/head).
- FSM and counters live in the top module.

Test Plan:
- Reset mid-XFER: reset after 3 beats of an 8-beat packet → w_inc=0, busy=0, burst_cnt=0, s_ready=1 immediately; no further writes.
- Single packet: 4 beats 0xA1..0xA4 with s_last on the 4th, hfull=0, wfull=0 → first w_inc 2 cycles after first acceptance; w_data sequence A1..A4; burst_cnt=1; busy=0 afterwards.
- Admission gate: hfull=1 with a packet pending → w_inc=0 and stall_cyc increments per cycle (stats enabled). Drop hfull → w_inc begins 2 cycles later.
- Full stall: wfull=1 for 5 cycles mid-burst → w_inc=0 throughout; state HOLD; no beat lost or duplicated; resumes in order when wfull=0.
- Over-length: 70-beat packet with MAX_BURST=64 → err_len=1 after beat 64, burst_cnt=2 after the last beat, all 70 beats written in order.
- Back-pressure: source holds s_valid=1 continuously while wfull=1 → s_ready drops after 2 accepted beats and rises again after the first pop.
